// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic register pipeline.
package pipe_pkg;

    // Bits needed to count 0..depth valid stages (at least one bit).
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid flag plus a data register.
// Data only loads when a valid word arrives, so bubbles never overwrite it.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);

    // Valid/data register: flush clears valid only, advance moves a word in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vout <= 1'b0;
            dout <= RESET_VAL;
        end else if (flush) begin
            vout <= 1'b0;
        end else if (adv) begin
            vout <= vin;
            if (vin) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline of DEPTH stages with valid/ready at both ends.
// A stage advances when it is empty or the stage after it advances, so
// bubbles collapse while the output is stalled.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic             accept;

    // Ready chain, computed from the output end back towards the input.
    always_comb begin
        adv          = '0;
        adv[DEPTH-1] = !v[DEPTH-1] | out_ready;
        for (int unsigned j = 1; j < DEPTH; j++) begin
            adv[DEPTH-1-j] = !v[DEPTH-1-j] | adv[DEPTH-j];
        end
    end

    assign in_ready  = adv[0] & !flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             vin_k;
        logic [WIDTH-1:0] din_k;

        if (k == 0) begin : g_head
            assign vin_k = accept;
            assign din_k = in_data;
        end else begin : g_body
            assign vin_k = v[k-1];
            assign din_k = d[k-1];
        end

        pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .adv   (adv[k]),
            .vin   (vin_k),
            .din   (din_k),
            .vout  (v[k]),
            .dout  (d[k])
        );
    end

    // Occupancy is the population count of the stage valid flags.
    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a vector table for the 8x3 chain plus
// hand-written sequences for asynchronous reset and a 1x1 chain.
module tb_pipe_reg_chain;

    logic       clk = 1'b0;
    logic       reset;

    // 8-bit, 3-deep instance
    logic       flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;

    // 1-bit, 1-deep instance
    logic       flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0] in_data1, out_data1;
    logic [0:0] occupancy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_reg_chain #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .occupancy (occupancy1)
    );

    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy;
        logic       fl;
        logic       e_ir;   // in_ready before the edge
        logic       e_ov;   // out_valid after the edge
        logic [7:0] e_od;   // out_data after the edge
        logic [1:0] e_occ;  // occupancy after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [7:0] din, input logic ordy,
                       input logic fl, input logic e_ir, input logic e_ov,
                       input logic [7:0] e_od, input logic [1:0] e_occ);
        vec_t t;
        t.iv = iv; t.din = din; t.ordy = ordy; t.fl = fl;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_occ = e_occ;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        // iv  din    ordy  fl    ir    ov    od     occ
        // stream with out_ready=1: first word out 2 edges after accept
        add(1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
        add(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2);
        add(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3);
        add(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd3);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd2);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 2'd0);
        // stalled output: 3 accepted, then frozen
        add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1);
        add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd2);
        add(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 2'd3);
        add(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3);
        add(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 2'd3);
        add(1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2'd3);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2'd3);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 2'd2);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd1);
        // refill behind a stalled output (bubble collapses), then full streaming
        add(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd2);
        add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 2'd3);
        add(1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd3);
        add(1'b1, 8'hB4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 2'd3);
        add(1'b1, 8'hB5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB3, 2'd3);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB4, 2'd2);
        // flush at occupancy 2 with an offered word
        add(1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB4, 2'd0);
        add(1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB4, 2'd1);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB4, 2'd1);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC2, 2'd1);
        add(1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC2, 2'd0);
        // flush on an empty chain still drops in_ready
        add(1'b1, 8'hD1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC2, 2'd0);

        reset = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 1'b0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h00);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].din;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_od));
            check($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
        end

        // asynchronous reset between edges at occupancy 2
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        in_data = 8'h6B;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_areset_occupancy", 32'(occupancy), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_occupancy", 32'(occupancy), 32'd0);
        check("areset_out_data",  32'(out_data),  32'h00);
        check("areset_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset = 1'b0;

        // 1-bit, 1-deep chain
        #1;
        check("d1_rst_out_valid", 32'(out_valid1), 32'd0);
        check("d1_rst_occupancy", 32'(occupancy1), 32'd0);
        check("d1_rst_in_ready",  32'(in_ready1),  32'd1);
        in_valid1 = 1'b1; in_data1 = 1'b1; out_ready1 = 1'b0;
        @(posedge clk);
        #1;
        check("d1_fill_out_valid", 32'(out_valid1), 32'd1);
        check("d1_fill_out_data",  32'(out_data1),  32'd1);
        check("d1_fill_occupancy", 32'(occupancy1), 32'd1);
        check("d1_full_in_ready",  32'(in_ready1),  32'd0);
        @(negedge clk);
        in_data1 = 1'b0; out_ready1 = 1'b1;
        #1;
        check("d1_pass_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        check("d1_pass_out_valid", 32'(out_valid1), 32'd1);
        check("d1_pass_out_data",  32'(out_data1),  32'd0);
        check("d1_pass_occupancy", 32'(occupancy1), 32'd1);
        @(negedge clk);
        in_valid1 = 1'b0; in_data1 = 1'b1;
        @(posedge clk);
        #1;
        check("d1_drain_out_valid", 32'(out_valid1), 32'd0);
        check("d1_drain_out_data",  32'(out_data1),  32'd0);
        check("d1_drain_occupancy", 32'(occupancy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
